// File: rtl/hazard_ctrl_fsm.sv
// Pipeline hazard controller: detects load-use, interrupt, return and taken-branch events in IDLE
// and plays out fixed-length stall/flush sequences on registered outputs.
module hazard_ctrl_fsm #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned LU_CYC  = 1,
    parameter int unsigned INT_CYC = 2,
    parameter int unsigned RET_CYC = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_mem_read,
    input  logic [ADDR_W-1:0]         ex_write_add,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic                      int_req,
    input  logic                      branch_taken,
    input  logic                      ret,
    output logic                      stall_pc,
    output logic                      stall_fd,
    output logic                      flush_fd,
    output logic                      flush_de,
    output logic                      flush_em,
    output logic                      int_ack,
    output logic                      busy
);

    localparam int unsigned MAX_LI  = (LU_CYC > INT_CYC) ? LU_CYC : INT_CYC;
    localparam int unsigned MAX_CYC = (MAX_LI > RET_CYC) ? MAX_LI : RET_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LU   = 3'd1;
    localparam logic [2:0] INT  = 3'd2;
    localparam logic [2:0] RET  = 3'd3;
    localparam logic [2:0] BR   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hit;
    logic             stall_pc_d, stall_fd_d, flush_fd_d, flush_de_d, flush_em_d;
    logic             int_ack_d, busy_d;

    // An unknown compare evaluates false in the if, so X/Z never produces a hit.
    always_comb begin
        lu_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_read && id_src_valid[i] &&
                (id_src[i*ADDR_W +: ADDR_W] == ex_write_add)) begin
                lu_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lu_hit) begin
                    state_d = LU;
                    cnt_d   = CNT_W'(LU_CYC - 1);
                end else if (int_req) begin
                    state_d = INT;
                    cnt_d   = CNT_W'(INT_CYC - 1);
                end else if (ret) begin
                    state_d = RET;
                    cnt_d   = CNT_W'(RET_CYC - 1);
                end else if (branch_taken) begin
                    state_d = BR;
                    cnt_d   = '0;
                end
            end
            LU, INT, RET, BR: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        stall_pc_d = 1'b0;
        stall_fd_d = 1'b0;
        flush_fd_d = 1'b0;
        flush_de_d = 1'b0;
        flush_em_d = 1'b0;
        int_ack_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_d)
            LU: begin
                stall_pc_d = 1'b1;
                stall_fd_d = 1'b1;
                flush_de_d = 1'b1;
            end
            INT: begin
                stall_pc_d = 1'b1;
                flush_fd_d = 1'b1;
                int_ack_d  = (cnt_d == '0);
            end
            RET: begin
                flush_fd_d = 1'b1;
                flush_de_d = 1'b1;
                flush_em_d = 1'b1;
            end
            BR: begin
                flush_fd_d = 1'b1;
                flush_de_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stall_pc <= 1'b0;
            stall_fd <= 1'b0;
            flush_fd <= 1'b0;
            flush_de <= 1'b0;
            flush_em <= 1'b0;
            int_ack  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stall_pc <= stall_pc_d;
            stall_fd <= stall_fd_d;
            flush_fd <= flush_fd_d;
            flush_de <= flush_de_d;
            flush_em <= flush_em_d;
            int_ack  <= int_ack_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Bench for hazard_ctrl_fsm: default instance plus a wider instance, each checked every cycle
// against a schedule-queue model, with literal expectations pinning the model.
module tb_hazard_ctrl_fsm;

    localparam int K_NONE = 0;
    localparam int K_LU   = 1;
    localparam int K_INT  = 2;
    localparam int K_RET  = 3;
    localparam int K_BR   = 4;

    localparam int A_LU = 1;
    localparam int B_LU = 2;
    localparam int X_INT = 2;
    localparam int X_RET = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: ADDR_W=3, NUM_SRC=2, LU_CYC=1
    logic       a_rd = 1'b0;
    logic [2:0] a_ex = '0;
    logic [5:0] a_src = '0;
    logic [1:0] a_val = '0;
    logic       a_int = 1'b0, a_br = 1'b0, a_ret = 1'b0;
    logic       a_spc, a_sfd, a_ffd, a_fde, a_fem, a_ack, a_bsy;
    logic [6:0] a_vec;
    assign a_vec = {a_bsy, a_ack, a_fem, a_fde, a_ffd, a_sfd, a_spc};

    // Instance B: ADDR_W=5, NUM_SRC=3, LU_CYC=2
    logic        b_rd = 1'b0;
    logic [4:0]  b_ex = '0;
    logic [14:0] b_src = '0;
    logic [2:0]  b_val = '0;
    logic        b_int = 1'b0, b_br = 1'b0, b_ret = 1'b0;
    logic        b_spc, b_sfd, b_ffd, b_fde, b_fem, b_ack, b_bsy;
    logic [6:0]  b_vec;
    assign b_vec = {b_bsy, b_ack, b_fem, b_fde, b_ffd, b_sfd, b_spc};

    hazard_ctrl_fsm #(
        .ADDR_W(3), .NUM_SRC(2), .LU_CYC(A_LU), .INT_CYC(X_INT), .RET_CYC(X_RET)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ex_mem_read(a_rd), .ex_write_add(a_ex), .id_src(a_src),
        .id_src_valid(a_val), .int_req(a_int), .branch_taken(a_br), .ret(a_ret),
        .stall_pc(a_spc), .stall_fd(a_sfd), .flush_fd(a_ffd), .flush_de(a_fde),
        .flush_em(a_fem), .int_ack(a_ack), .busy(a_bsy)
    );

    hazard_ctrl_fsm #(
        .ADDR_W(5), .NUM_SRC(3), .LU_CYC(B_LU), .INT_CYC(X_INT), .RET_CYC(X_RET)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_mem_read(b_rd), .ex_write_add(b_ex), .id_src(b_src),
        .id_src_valid(b_val), .int_req(b_int), .branch_taken(b_br), .ret(b_ret),
        .stall_pc(b_spc), .stall_fd(b_sfd), .flush_fd(b_ffd), .flush_de(b_fde),
        .flush_em(b_fem), .int_ack(b_ack), .busy(b_bsy)
    );

    // Output vector {busy, int_ack, flush_em, flush_de, flush_fd, stall_fd, stall_pc}
    function automatic logic [6:0] seq_vec(input int kind, input int idx, input int len);
        case (kind)
            K_LU:    return 7'b100_1011;
            K_INT:   return (idx == len - 1) ? 7'b110_0101 : 7'b100_0101;
            K_RET:   return 7'b101_1100;
            K_BR:    return 7'b100_1100;
            default: return 7'b000_0000;
        endcase
    endfunction

    // Model: once idle, an accepted event appends its whole output schedule to a queue.
    logic [6:0] qa[$];
    logic [6:0] qb[$];
    logic [6:0] exp_a = '0;
    logic [6:0] exp_b = '0;

    always @(posedge clk or negedge rst_n) begin : model_a
        int kind;
        int len;
        logic hit;
        if (!rst_n) begin
            qa.delete();
            exp_a <= '0;
        end else begin
            if (qa.size() == 0 && exp_a[6] == 1'b0) begin
                hit = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (a_val[i] === 1'b1 && !$isunknown(a_src[i*3 +: 3]) &&
                        a_src[i*3 +: 3] === a_ex) hit = 1'b1;
                end
                if (a_rd !== 1'b1 || $isunknown(a_ex)) hit = 1'b0;
                kind = K_NONE;
                len  = 0;
                if (hit)                 begin kind = K_LU;  len = A_LU;  end
                else if (a_int === 1'b1) begin kind = K_INT; len = X_INT; end
                else if (a_ret === 1'b1) begin kind = K_RET; len = X_RET; end
                else if (a_br === 1'b1)  begin kind = K_BR;  len = 1;     end
                for (int k = 0; k < len; k++) qa.push_back(seq_vec(kind, k, len));
            end
            if (qa.size() > 0) exp_a <= qa.pop_front();
            else               exp_a <= '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin : model_b
        int kind;
        int len;
        logic hit;
        if (!rst_n) begin
            qb.delete();
            exp_b <= '0;
        end else begin
            if (qb.size() == 0 && exp_b[6] == 1'b0) begin
                hit = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (b_val[i] === 1'b1 && !$isunknown(b_src[i*5 +: 5]) &&
                        b_src[i*5 +: 5] === b_ex) hit = 1'b1;
                end
                if (b_rd !== 1'b1 || $isunknown(b_ex)) hit = 1'b0;
                kind = K_NONE;
                len  = 0;
                if (hit)                 begin kind = K_LU;  len = B_LU;  end
                else if (b_int === 1'b1) begin kind = K_INT; len = X_INT; end
                else if (b_ret === 1'b1) begin kind = K_RET; len = X_RET; end
                else if (b_br === 1'b1)  begin kind = K_BR;  len = 1;     end
                for (int k = 0; k < len; k++) qb.push_back(seq_vec(kind, k, len));
            end
            if (qb.size() > 0) exp_b <= qb.pop_front();
            else               exp_b <= '0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (a_vec !== exp_a) begin
            failures++;
            $display("FAIL model_a t=%0t actual=%b required=%b", $time, a_vec, exp_a);
        end
        checks++;
        if (b_vec !== exp_b) begin
            failures++;
            $display("FAIL model_b t=%0t actual=%b required=%b", $time, b_vec, exp_b);
        end
    end

    task automatic lit(input string name, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        a_rd = 1'b0; a_ex = '0; a_src = '0; a_val = '0;
        a_int = 1'b0; a_br = 1'b0; a_ret = 1'b0;
    endtask

    task automatic clr_b();
        b_rd = 1'b0; b_ex = '0; b_src = '0; b_val = '0;
        b_int = 1'b0; b_br = 1'b0; b_ret = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lit("reset_a", a_vec, 7'h00);
        lit("reset_b", b_vec, 7'h00);

        // Load-use on operand 1 (both operands valid)
        a_rd = 1'b1; a_ex = 3'd5; a_src = {3'd5, 3'd2}; a_val = 2'b11;
        tick(); clr_a();
        @(negedge clk) lit("lu_c1", a_vec, 7'h4B);
        @(negedge clk) lit("lu_done", a_vec, 7'h00);

        // Address match only on an invalid operand
        a_rd = 1'b1; a_ex = 3'd5; a_src = {3'd2, 3'd5}; a_val = 2'b10;
        tick(); clr_a();
        @(negedge clk) lit("lu_invalid_op", a_vec, 7'h00);

        // Interrupt pulse
        a_int = 1'b1;
        tick(); clr_a();
        @(negedge clk) lit("int_c1", a_vec, 7'h45);
        @(negedge clk) lit("int_c2_ack", a_vec, 7'h65);
        @(negedge clk) lit("int_done", a_vec, 7'h00);

        // Interrupt held: re-accepted after one IDLE cycle
        a_int = 1'b1;
        tick();
        @(negedge clk) lit("int_hold_c1", a_vec, 7'h45);
        @(negedge clk) lit("int_hold_c2", a_vec, 7'h65);
        @(negedge clk) lit("int_hold_idle", a_vec, 7'h00);
        @(negedge clk) lit("int_hold_again", a_vec, 7'h45);
        a_int = 1'b0;
        @(negedge clk) lit("int_hold_ack2", a_vec, 7'h65);
        @(negedge clk) lit("int_hold_done", a_vec, 7'h00);

        // All events at once, held through the busy cycle
        a_rd = 1'b1; a_ex = 3'd5; a_src = {3'd5, 3'd2}; a_val = 2'b11;
        a_int = 1'b1; a_ret = 1'b1; a_br = 1'b1;
        tick();
        @(negedge clk) lit("all_events_lu", a_vec, 7'h4B);
        tick(); clr_a();
        @(negedge clk) lit("all_events_dropped", a_vec, 7'h00);

        // Return
        a_ret = 1'b1;
        tick(); clr_a();
        @(negedge clk) lit("ret_c1", a_vec, 7'h5C);
        @(negedge clk) lit("ret_c2", a_vec, 7'h5C);
        @(negedge clk) lit("ret_c3", a_vec, 7'h5C);
        @(negedge clk) lit("ret_done", a_vec, 7'h00);

        // Taken branch
        a_br = 1'b1;
        tick(); clr_a();
        @(negedge clk) lit("br_c1", a_vec, 7'h4C);
        @(negedge clk) lit("br_done", a_vec, 7'h00);

        // Asynchronous reset in the second RET cycle
        a_ret = 1'b1;
        tick(); clr_a();
        @(negedge clk) lit("rst_ret_c1", a_vec, 7'h5C);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", a_vec, 7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        a_br = 1'b1;
        tick(); clr_a();
        @(negedge clk) lit("br_after_reset", a_vec, 7'h4C);
        @(negedge clk) lit("br_after_reset_done", a_vec, 7'h00);

        // Wide instance: match on operand 2 stalls two cycles
        b_rd = 1'b1; b_ex = 5'd17; b_src = {5'd17, 5'd3, 5'd9}; b_val = 3'b111;
        tick(); clr_b();
        @(negedge clk) lit("lu3_c1", b_vec, 7'h4B);
        @(negedge clk) lit("lu3_c2", b_vec, 7'h4B);
        @(negedge clk) lit("lu3_done", b_vec, 7'h00);

        // Unknown source address never matches
        b_rd = 1'b1; b_ex = 5'd10; b_src = {5'bxxxxx, 5'd3, 5'd9}; b_val = 3'b111;
        tick(); clr_b();
        @(negedge clk) lit("lu_x_src", b_vec, 7'h00);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_fsm.md
Name: hazard_ctrl_fsm

Overview:
Parametrised, FSM-based successor to the pipeline hazard detection unit. It detects load-use hazards across NUM_SRC decode-stage source operands, interrupt entry, return (ret/rti) and taken branches. For each event it drives multi-cycle stall and flush sequences whose lengths are set by parameters. Sits beside the pipeline registers: stall/flush outputs feed the PC and the F/D, D/E and E/M buffers.

Parameters:
ADDR_W, 3, register address width
NUM_SRC, 2, number of decode-stage source operands compared
LU_CYC, 1, load-use stall length in cycles (>=1)
INT_CYC, 2, interrupt stall length in cycles (>=1)
RET_CYC, 3, ret/rti flush length in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_mem_read  in  1  instruction in EX is a load
ex_write_add  in  ADDR_W  destination register of the EX instruction
id_src  in  NUM_SRC*ADDR_W  decode source addresses; operand i is at bits [i*ADDR_W +: ADDR_W]
id_src_valid  in  NUM_SRC  per-operand valid
int_req  in  1  interrupt request (level)
branch_taken  in  1  taken branch/jmp resolved
ret  in  1  ret or rti resolved
stall_pc  out  1  hold PC
stall_fd  out  1  hold F/D buffer
flush_fd  out  1  clear F/D buffer
flush_de  out  1  clear D/E buffer (insert bubble)
flush_em  out  1  clear E/M buffer
int_ack  out  1  one-cycle interrupt-accepted pulse
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, all outputs 0. Reset asserted mid-sequence aborts the sequence immediately.
- All outputs are registered Moore outputs. An event sampled at edge N takes effect in the cycle after edge N and holds for the programmed length.
- States: IDLE, LU, INT, RET, BR. A hidden down-counter is sized clog2(max(LU_CYC,INT_CYC,RET_CYC)+1).
- Load-use match: ex_mem_read=1 and, for some i, id_src_valid[i]=1 and id_src[i]==ex_write_add. An X or Z on any compared bit counts as no match.
- Events are sampled only in IDLE, with priority load-use > int_req > ret > branch_taken. Lower-priority events in the same cycle are dropped; upstream holds or re-presents them.
- IDLE -> LU: counter=LU_CYC-1. Outputs stall_pc=1, stall_fd=1, flush_de=1.
- IDLE -> INT: counter=INT_CYC-1. Outputs stall_pc=1, flush_fd=1. int_ack=1 only in the last INT cycle.
- IDLE -> RET: counter=RET_CYC-1. Outputs flush_fd=1, flush_de=1, flush_em=1. No stall.
- IDLE -> BR: exactly one cycle. Outputs flush_fd=1, flush_de=1.
- Non-IDLE states decrement the counter each cycle and return to IDLE when the counter is 0 at the edge. Inputs are ignored while busy=1.
- After returning to IDLE, a still-asserted int_req is treated as a new interrupt. The requester must drop int_req on int_ack.
- Back-to-back events: the earliest detection is the first IDLE cycle after a sequence ends. There is no implicit idle gap beyond that cycle.
- busy = (state != IDLE), registered with the state.
- Outputs not listed for a state are 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_add=3'd5, id_src={3'd5,3'd2}, valid=2'b11 (LU_CYC=1) -> stall_pc, stall_fd, flush_de high exactly 1 cycle, then IDLE. With valid=2'b10 and a matching address only on operand 0 -> no stall.
- Interrupt, INT_CYC=2: int_req pulse -> stall_pc and flush_fd high 2 cycles, int_ack high in cycle 2 only. int_req held high -> second INT sequence starts the cycle after IDLE is re-entered.
- Simultaneous load-use, int_req, ret and branch_taken in IDLE -> LU sequence only, no int_ack. The others are ignored during busy.
- ret with RET_CYC=3 -> flush_fd, flush_de, flush_em high 3 consecutive cycles, stall_pc=0. branch_taken -> flush_fd and flush_de high 1 cycle.
- rst_n driven low in the 2nd cycle of RET -> all outputs 0 asynchronously, state IDLE. After release, the next event is handled normally.
- Parameter sweep: ADDR_W=5, NUM_SRC=3, LU_CYC=2 -> match on operand 2 stalls 2 cycles. X on id_src gives no stall.
